// File: rtl/edge_event_arbiter_if.sv
// Event bundle between the edge/event arbiter and its environment.
// Latency: none, wires only.
// Backpressure: ev_ready from the consumer stalls ev_valid/ev_id.
//
// Ports (grouped):
//   level, enable, clr_overrun : per-channel inputs to the arbiter
//   ev_valid, ev_id, ev_ready  : single event channel, valid/ready handshake
//   pending, overrun           : per-channel status from the arbiter
interface edge_event_arbiter_if #(
    parameter int N    = 4,
    parameter int ID_W = 2
);
    logic [N-1:0]    level;
    logic [N-1:0]    enable;
    logic [N-1:0]    clr_overrun;
    logic            ev_valid;
    logic [ID_W-1:0] ev_id;
    logic            ev_ready;
    logic [N-1:0]    pending;
    logic [N-1:0]    overrun;

    // master: the arbiter itself
    modport master (
        input  level, enable, clr_overrun, ev_ready,
        output ev_valid, ev_id, pending, overrun
    );

    // slave: the input source plus event consumer
    modport slave (
        output level, enable, clr_overrun, ev_ready,
        input  ev_valid, ev_id, pending, overrun
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Rising-edge detection on N level inputs, latched as pending events, round-robin onto one event channel.
// Latency: level sampled high at edge t -> pending after t+1 -> ev_valid after t+2 (arbiter idle, channel wins).
// Backpressure: ev_valid/ev_id held until ev_ready; extra edges on a pending channel set sticky overrun.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : edge_event_arbiter_if.master (level/enable/clr_overrun in, ev_* handshake, pending/overrun out)
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    edge_event_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        CH_ZERO = 2'd0,
        CH_EDG  = 2'd1,
        CH_ONE  = 2'd2
    } ch_state_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;

    ch_state_t       ch_st [N];
    logic [N-1:0]    tick;
    logic [N-1:0]    set_vec;
    logic [N-1:0]    clr_vec;
    logic [N-1:0]    pending_q;
    logic [N-1:0]    overrun_q;
    logic            hs;

    arb_state_t      arb_st;
    logic            ev_valid_q;
    logic [ID_W-1:0] ev_id_q;
    logic [ID_W-1:0] last_grant_q;
    logic            pick_vld;
    logic [ID_W-1:0] pick_id;

    // ------------------------------------------------------------------
    // Per-channel Moore edge detectors. EDG lasts exactly one cycle, so a
    // one-cycle pulse still yields a tick, and a level already high when
    // reset drops is seen as a fresh edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                ch_st[i] <= CH_ZERO;
            end else begin
                case (ch_st[i])
                    CH_ZERO: ch_st[i] <= bus.level[i] ? CH_EDG : CH_ZERO;
                    CH_EDG:  ch_st[i] <= bus.level[i] ? CH_ONE : CH_ZERO;
                    CH_ONE:  ch_st[i] <= bus.level[i] ? CH_ONE : CH_ZERO;
                    default: ch_st[i] <= CH_ZERO;
                endcase
            end
        end
    end

    always_comb begin
        tick = '0;
        for (int i = 0; i < N; i++) begin
            tick[i] = (ch_st[i] == CH_EDG);
        end
    end

    // ------------------------------------------------------------------
    // Pending / overrun. A new tick on the channel being handed off this
    // cycle re-arms pending without counting as an overrun.
    // ------------------------------------------------------------------
    assign hs      = ev_valid_q & bus.ev_ready;
    assign set_vec = tick & bus.enable;
    assign clr_vec = hs ? ({{(N-1){1'b0}}, 1'b1} << ev_id_q) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= set_vec | (pending_q & ~clr_vec);
            overrun_q <= (set_vec & pending_q & ~clr_vec) | (overrun_q & ~bus.clr_overrun);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: the pending channel closest after last_grant
    // (distance counted modulo N) wins. Distance form avoids variable
    // indexing and works for any N, power of two or not.
    // ------------------------------------------------------------------
    always_comb begin
        int best;
        int d;
        best     = N;
        d        = 0;
        pick_id  = '0;
        pick_vld = |pending_q;
        for (int i = 0; i < N; i++) begin
            d = i + N - 1 - int'(last_grant_q);
            if (d >= N) begin
                d = d - N;
            end
            if (pending_q[i] && (d < best)) begin
                best    = d;
                pick_id = ID_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter. The grant is locked for the whole OFFER; the return to IDLE
    // after each handshake gives the pending clear one cycle to land before
    // the next pick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            arb_st       <= ARB_IDLE;
            ev_valid_q   <= 1'b0;
            ev_id_q      <= '0;
            last_grant_q <= ID_W'(N - 1);
        end else begin
            case (arb_st)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        ev_id_q    <= pick_id;
                        ev_valid_q <= 1'b1;
                        arb_st     <= ARB_OFFER;
                    end else begin
                        ev_valid_q <= 1'b0;
                    end
                end
                ARB_OFFER: begin
                    if (bus.ev_ready) begin
                        last_grant_q <= ev_id_q;
                        ev_valid_q   <= 1'b0;
                        arb_st       <= ARB_IDLE;
                    end
                end
                default: begin
                    ev_valid_q <= 1'b0;
                    arb_st     <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.ev_valid = ev_valid_q;
    assign bus.ev_id    = ev_id_q;
    assign bus.pending  = pending_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Watches N level inputs (buttons, sensor lines). Each channel has its own Moore-style rising-edge detector.
- Each detected edge is latched as a pending event.
- Pending events are shared onto one event channel with a valid/ready handshake, granted round-robin.
- Sits between the raw synchronized inputs and the single event consumer (e.g. a control FSM or a counter bank). It also flags events lost to overrun.

Parameters:
- N, 4, number of level channels (2..16).
- ID_W, 2, width of event ID; must satisfy 2**ID_W >= N.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- level  input  N  per-channel level inputs, already synchronized to clk.
- enable  input  N  per-channel enable; a tick on a disabled channel is discarded.
- ev_valid  output  1  event offered to consumer.
- ev_id  output  ID_W  channel index of the offered event.
- ev_ready  input  1  consumer accepts the event when ev_valid && ev_ready.
- pending  output  N  per-channel pending-event flags.
- overrun  output  N  sticky per-channel flag: an edge arrived while that channel was already pending.
- clr_overrun  input  N  per-bit clear pulse for overrun.

Behaviour:
- Reset: synchronous, active-high (reset sampled high at a rising clk edge). All state clears:
  - outputs: ev_valid=0, ev_id=0, pending=0, overrun=0;
  - channel FSMs go to ZERO; arbiter goes to IDLE; last_grant=N-1.
- Channel FSM, one per channel, states ZERO/EDG/ONE:
  - ZERO: level=1 -> EDG, else stay.
  - EDG: tick_i=1 for this cycle only. level=1 -> ONE, else -> ZERO.
  - ONE: level=0 -> ZERO, else stay.
  - Unused encoding -> ZERO.
- Level high at reset release is treated as a rising edge (ZERO->EDG) and produces one event.
- Pending update, per channel, each edge:
  - Set when tick_i && enable_i.
  - Clear when a handshake completes with ev_id==i.
  - Set and clear in the same cycle: set wins, and no overrun is flagged.
  - Disabling a channel does not clear an existing pending bit.
- Overrun:
  - Set when tick_i && enable_i && pending_i && not cleared this cycle.
  - Cleared by clr_overrun_i; set wins over a simultaneous clear.
- Arbiter FSM, states IDLE/OFFER:
  - IDLE: if pending != 0, pick the first pending channel scanning last_grant+1, +2, ..., wrapping modulo N. Register ev_id, ev_valid<=1, go to OFFER. Otherwise ev_valid=0.
  - OFFER: ev_valid and ev_id held stable until ev_ready=1. On the handshake: clear pending[ev_id], last_grant<=ev_id, ev_valid<=0, go to IDLE.
  - ev_ready is ignored while ev_valid=0.
- Latency: level first sampled 1 at edge t -> pending_i=1 after edge t+1 -> ev_valid=1 after edge t+2, provided the arbiter is IDLE and channel i wins.
- Throughput: at most one event per 2 cycles, because of a mandatory IDLE bubble after each handshake.
- Grant is locked once offered: a newly pending, higher-priority channel does not change ev_id during OFFER.
- Level pulses must last at least 1 cycle. A pulse of exactly 1 cycle still yields one tick.
- Reset mid-OFFER: the event is dropped (ev_valid=0 the next cycle) and all pending events are lost.

Test Plan:
- Reset, then raise level[2] and hold; ev_ready=1 -> ev_valid=1 with ev_id=2 exactly 2 cycles after level is sampled high; one handshake; pending=0; no further events while level[2] stays high.
- level[0], level[1], level[3] rise in the same cycle, ev_ready=1 -> events in order 0,1,3, each separated by one bubble cycle; then raise level[0] and level[3] together -> order 0,3 (last_grant=3 wraps to 0).
- ev_ready=0 for 5 cycles while ev_id=1 is offered, and level[0] rises meanwhile -> ev_id stays 1 with ev_valid held; after ev_ready=1 the next event is 0.
- Two pulses on level[1] while its pending bit is set and ev_ready=0 -> overrun[1]=1; then clr_overrun[1] pulse -> overrun[1]=0; clr_overrun coincident with a new overrun -> overrun stays 1.
- Tick on channel 2 in the same cycle as the handshake of ev_id=2 -> pending[2] remains 1, overrun[2]=0, and a second event for ID 2 follows.
- enable[3]=0 with an edge on level[3] -> no pending and no event. Assert reset during OFFER -> next cycle ev_valid=0, pending=0, last_grant=N-1, so channel 0 wins first afterwards.
